// File: rtl/acc_sedes_dummy.sv
// Stand-in accelerator: consumes S words, waits W cycles, then emits D words derived from their sum.
// Optional statistics counters are enabled by defining ACC_SEDES_DUMMY_STATS_EN.
module acc_sedes_dummy #(
    parameter int DATA_W  = 64,
    parameter int RATIO_W = 16,
    parameter int WAIT_W  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RATIO_W-1:0] serialization_ratio,
    input  logic [RATIO_W-1:0] deserialization_ratio,
    input  logic [WAIT_W-1:0]  wait_cycles,
    input  logic               consumer_valid,
    output logic               consumer_ready,
    input  logic [DATA_W-1:0]  consumer_data,
    output logic               producer_valid,
    input  logic               producer_ready,
    output logic [DATA_W-1:0]  producer_data,
    output logic               busy,
    output logic [31:0]        batch_count,
    output logic [31:0]        stall_count
);

    // Handshakes: a word moves on a rising clk edge where valid and ready are both high.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONSUME = 2'd1,
        S_WAIT    = 2'd2,
        S_PRODUCE = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                ready_q;
    logic [RATIO_W-1:0]  s_lat;
    logic [RATIO_W-1:0]  d_lat;
    logic [WAIT_W-1:0]   w_lat;
    logic [RATIO_W-1:0]  s_cnt;
    logic [RATIO_W-1:0]  d_cnt;
    logic [WAIT_W-1:0]   w_cnt;
    logic [DATA_W-1:0]   acc;
    logic [RATIO_W-1:0]  s_in;
    logic [RATIO_W-1:0]  d_in;
    logic                c_hs;
    logic                p_hs;
    logic                p_last;

    assign s_in   = (serialization_ratio == '0) ? RATIO_W'(1) : serialization_ratio;
    assign d_in   = (deserialization_ratio == '0) ? RATIO_W'(1) : deserialization_ratio;
    assign c_hs   = consumer_valid & ready_q;
    assign p_hs   = producer_valid & producer_ready;
    assign p_last = p_hs && (d_cnt == d_lat - RATIO_W'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (c_hs) begin
                    if (s_in == RATIO_W'(1))
                        state_d = (wait_cycles != '0) ? S_WAIT : S_PRODUCE;
                    else
                        state_d = S_CONSUME;
                end
            end
            S_CONSUME: begin
                if (c_hs && (s_cnt == s_lat - RATIO_W'(1)))
                    state_d = (w_lat != '0) ? S_WAIT : S_PRODUCE;
            end
            S_WAIT: begin
                if (w_cnt == w_lat)
                    state_d = S_PRODUCE;
            end
            S_PRODUCE: begin
                if (p_last)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // consumer_ready is registered from the next state so it stays low while rst is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            s_lat   <= '0;
            d_lat   <= '0;
            w_lat   <= '0;
            s_cnt   <= '0;
            d_cnt   <= '0;
            w_cnt   <= '0;
            acc     <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE) || (state_d == S_CONSUME);
            case (state_q)
                S_IDLE: begin
                    if (c_hs) begin
                        s_lat <= s_in;
                        d_lat <= d_in;
                        w_lat <= wait_cycles;
                        acc   <= consumer_data;
                        s_cnt <= RATIO_W'(1);
                        d_cnt <= '0;
                        w_cnt <= WAIT_W'(1);
                    end
                end
                S_CONSUME: begin
                    if (c_hs) begin
                        acc   <= acc + consumer_data;
                        s_cnt <= s_cnt + RATIO_W'(1);
                    end
                end
                S_WAIT: begin
                    w_cnt <= w_cnt + WAIT_W'(1);
                end
                S_PRODUCE: begin
                    if (p_hs)
                        d_cnt <= d_cnt + RATIO_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign consumer_ready = ready_q;
    assign producer_valid = (state_q == S_PRODUCE);
    assign producer_data  = producer_valid ? (acc + DATA_W'(d_cnt)) : '0;
    assign busy           = (state_q != S_IDLE);

`ifdef ACC_SEDES_DUMMY_STATS_EN
    logic [31:0] batch_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            batch_q <= '0;
            stall_q <= '0;
        end else begin
            if (p_last)
                batch_q <= batch_q + 32'd1;
            if (producer_valid && !producer_ready)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign batch_count = batch_q;
    assign stall_count = stall_q;
`else
    assign batch_count = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_acc_sedes_dummy.sv
// Directed bench for acc_sedes_dummy (DATA_W=8) with an expected-output queue and a negedge monitor.
module tb_acc_sedes_dummy;

    localparam int DW = 8;
    localparam int RW = 16;
    localparam int WW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] serialization_ratio;
    logic [RW-1:0] deserialization_ratio;
    logic [WW-1:0] wait_cycles;
    logic          consumer_valid;
    logic          consumer_ready;
    logic [DW-1:0] consumer_data;
    logic          producer_valid;
    logic          producer_ready;
    logic [DW-1:0] producer_data;
    logic          busy;
    logic [31:0]   batch_count;
    logic [31:0]   stall_count;

    int            checks = 0;
    int            passes = 0;
    int            cyc = 0;
    int            hs_cyc = 0;
    int            exp_lat = 0;
    logic [DW-1:0] exp_q[$];
    logic          prev_pv = 1'b0;
    logic          prev_pr = 1'b0;
    logic [DW-1:0] prev_data = '0;

    acc_sedes_dummy #(.DATA_W(DW), .RATIO_W(RW), .WAIT_W(WW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .serialization_ratio   (serialization_ratio),
        .deserialization_ratio (deserialization_ratio),
        .wait_cycles           (wait_cycles),
        .consumer_valid        (consumer_valid),
        .consumer_ready        (consumer_ready),
        .consumer_data         (consumer_data),
        .producer_valid        (producer_valid),
        .producer_ready        (producer_ready),
        .producer_data         (producer_data),
        .busy                  (busy),
        .batch_count           (batch_count),
        .stall_count           (stall_count)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (producer_valid) check("ready_valid_exclusive", consumer_ready, 0);
            if (producer_valid && !prev_pv) check("first_valid_latency", cyc - hs_cyc, exp_lat);
            if (producer_valid && prev_pv && !prev_pr) check("hold_data", producer_data, prev_data);
            if (producer_valid && producer_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got %0d, expected no output", producer_data);
                end else begin
                    check("out_data", producer_data, exp_q.pop_front());
                end
            end
        end
        prev_pv   = producer_valid;
        prev_pr   = producer_ready;
        prev_data = producer_data;
    end

    // driver tasks: called just after a negedge, return just after a negedge
    task automatic send_word(input logic [DW-1:0] d);
        int n = 0;
        consumer_valid = 1'b1;
        consumer_data  = d;
        while (!consumer_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!consumer_ready) begin
            check("send_timeout", consumer_ready, 1);
            consumer_valid = 1'b0;
            return;
        end
        hs_cyc = cyc;
        @(negedge clk);
        consumer_valid = 1'b0;
    endtask

    task automatic config_batch(input int s, input int d, input int w);
        serialization_ratio   = RW'(s);
        deserialization_ratio = RW'(d);
        wait_cycles           = WW'(w);
        exp_lat               = w + 1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        @(negedge clk);
        check({name, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        serialization_ratio = '0;
        deserialization_ratio = '0;
        wait_cycles = '0;
        consumer_valid = 1'b0;
        consumer_data = '0;
        producer_ready = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_consumer_ready", consumer_ready, 0);
        check("rst_producer_valid", producer_valid, 0);
        check("rst_producer_data", producer_data, 0);
        check("rst_busy", busy, 0);
        check("rst_batch_count", batch_count, 0);
        check("rst_stall_count", stall_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", consumer_ready, 1);

        // S=4 D=2 W=3: sum 10 -> 10, 11
        config_batch(4, 2, 3);
        exp_q.push_back(8'd10);
        exp_q.push_back(8'd11);
        send_word(8'd1);
        send_word(8'd2);
        send_word(8'd3);
        send_word(8'd4);
        drain("basic");

        // zero ratios behave as 1, zero wait
        config_batch(0, 0, 0);
        exp_q.push_back(8'h05);
        send_word(8'h05);
        drain("zero_ratio");

        // 0xFF + 0x02 wraps to 0x01
        config_batch(2, 3, 2);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        send_word(8'hFF);
        send_word(8'h02);
        drain("wrap");

        // five stalled cycles in S_PRODUCE
        config_batch(1, 2, 0);
        producer_ready = 1'b0;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        send_word(8'h10);
        begin
            int n = 0;
            while (!producer_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("stall_valid_seen", producer_valid, 1);
        end
        repeat (5) @(negedge clk);
        producer_ready = 1'b1;
        drain("stall");
`ifdef ACC_SEDES_DUMMY_STATS_EN
        check("stall_count", stall_count, 5);
        check("batch_count", batch_count, 4);
`else
        check("stall_count", stall_count, 0);
        check("batch_count", batch_count, 0);
`endif

        // ratio change mid-batch is ignored until the next batch
        config_batch(3, 1, 0);
        exp_q.push_back(8'd6);
        send_word(8'd1);
        serialization_ratio = RW'(1);
        send_word(8'd2);
        send_word(8'd3);
        drain("latched_cfg");
        exp_q.push_back(8'd9);
        send_word(8'd9);
        drain("next_cfg");

        // reset during S_WAIT aborts the batch
        config_batch(1, 1, 10);
        exp_q.push_back(8'h20);
        send_word(8'h20);
        repeat (3) @(negedge clk);
        check("busy_in_wait", busy, 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_consumer_ready", consumer_ready, 0);
        check("abort_producer_valid", producer_valid, 0);
        check("abort_producer_data", producer_data, 0);
        check("abort_busy", busy, 0);
        check("abort_batch_count", batch_count, 0);
        check("abort_stall_count", stall_count, 0);
        rst = 1'b0;
        @(negedge clk);
        config_batch(1, 1, 0);
        exp_q.push_back(8'd7);
        send_word(8'd7);
        drain("after_abort");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        $display("FAIL global_timeout: time %0t, expected finish before 200000", $time);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
